// File: rtl/toggle_ctrl.sv
// Square-wave stimulus generator with a latency-matched response checker.
// Drives drv for n toggles of hp cycles each, then counts rsp mismatches after LAT cycles.
module toggle_ctrl #(
  parameter int HP_W = 16,
  parameter int N_W  = 8,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [HP_W-1:0] half_period,
  input  logic [N_W-1:0]  n_toggles,
  output logic            drv,
  input  logic            rsp,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'((LAT > 0) ? LAT - 1 : 0);

  state_t          state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [N_W-1:0]  n_q, n_d;
  logic [HP_W-1:0] phase_q, phase_d;
  logic [N_W-1:0]  tog_q, tog_d;
  logic [3:0]      drain_q, drain_d;
  logic            drv_q, drv_d;
  logic [15:0]     err_q, err_d;

  logic run;
  logic cmp_vld;
  logic cmp_drv;

  assign run = (state_q == S_RUN);

  // Delay the drive level and a RUN marker by LAT so each compare lines up
  // with the response to the stimulus applied LAT cycles earlier.
  generate
    if (LAT == 0) begin : g_nolat
      assign cmp_vld = run;
      assign cmp_drv = drv_q;
    end else begin : g_lat
      logic [LAT-1:0] vld_pipe_q;
      logic [LAT-1:0] drv_pipe_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_pipe_q <= '0;
          drv_pipe_q <= '1;
        end else begin
          vld_pipe_q[0] <= run;
          drv_pipe_q[0] <= drv_q;
          for (int i = 1; i < LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            drv_pipe_q[i] <= drv_pipe_q[i-1];
          end
        end
      end

      assign cmp_vld = vld_pipe_q[LAT-1];
      assign cmp_drv = drv_pipe_q[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hp_q    <= HP_W'(1);
      n_q     <= '0;
      phase_q <= '0;
      tog_q   <= '0;
      drain_q <= '0;
      drv_q   <= 1'b1;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      n_q     <= n_d;
      phase_q <= phase_d;
      tog_q   <= tog_d;
      drain_q <= drain_d;
      drv_q   <= drv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    n_d     = n_q;
    phase_d = phase_q;
    tog_d   = tog_q;
    drain_d = drain_q;
    drv_d   = drv_q;
    err_d   = err_q;

    if (cmp_vld && (rsp != cmp_drv) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          hp_d    = (half_period == '0) ? HP_W'(1) : half_period;
          n_d     = n_toggles;
          drv_d   = 1'b1;
          err_d   = '0;
          phase_d = '0;
          tog_d   = '0;
          drain_d = '0;
          state_d = (n_toggles != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (phase_q == hp_q - HP_W'(1)) begin
          drv_d   = ~drv_q;
          phase_d = '0;
          tog_d   = tog_q + N_W'(1);
          // tog_q is pre-increment, so this is the cycle of the n-th toggle
          if (tog_q == n_q - N_W'(1)) begin
            state_d = (LAT == 0) ? S_DONE : S_DRAIN;
            drain_d = '0;
          end
        end else begin
          phase_d = phase_q + HP_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign drv     = drv_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_toggle_ctrl.sv
// Scoreboard bench for toggle_ctrl: stimulus queues expected sequence results,
// a negedge monitor measures each sequence and checks it when done pulses.
module tb_toggle_ctrl;

  localparam int HP_W = 16;
  localparam int N_W  = 8;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [HP_W-1:0] half_period;
  logic [N_W-1:0]  n_toggles;
  logic            drv;
  logic            rsp;
  logic            busy;
  logic            done;
  logic [15:0]     err_cnt;

  logic       inv;
  logic [1:0] chain;

  typedef struct {
    int hp;
    int err;
    int drv;
    int busy;
    int tog;
    int lat;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   done_seen = 0;

  toggle_ctrl #(.HP_W(HP_W), .N_W(N_W), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .half_period(half_period),
    .n_toggles  (n_toggles),
    .drv        (drv),
    .rsp        (rsp),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Model of the device under stimulus: a two-flop delay, optionally inverted.
  always @(posedge clk or posedge rst) begin
    if (rst) chain <= 2'b11;
    else     chain <= {chain[0], drv};
  end
  assign rsp = chain[1] ^ inv;

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Monitor
  int   busy_cnt, tog_cnt, lat_cnt, run_len;
  bit   armed, bad_iv, prev_busy;
  logic prev_drv;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0; tog_cnt = 0; lat_cnt = 0; run_len = 0;
      armed = 0; bad_iv = 0; prev_busy = 0; prev_drv = drv;
    end else begin
      if (armed) lat_cnt++;
      if (busy) begin
        busy_cnt++;
        if (!prev_busy) begin
          run_len = 1;
        end else if (drv !== prev_drv) begin
          tog_cnt++;
          if (q.size() > 0 && run_len != q[0].hp) bad_iv = 1;
          run_len = 1;
        end else begin
          run_len++;
        end
      end
      if (done) begin
        done_seen++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("err_cnt_at_done", int'(err_cnt), e.err);
          chk("final_drv", int'(drv), e.drv);
          chk("busy_cycles", busy_cnt, e.busy);
          chk("toggle_count", tog_cnt, e.tog);
          chk("done_latency", lat_cnt, e.lat);
          chk("half_period_intervals_bad", int'(bad_iv), 0);
        end
        busy_cnt = 0; tog_cnt = 0; lat_cnt = 0; armed = 0; bad_iv = 0;
      end
      if (start && !busy && !done) begin
        armed = 1;
        lat_cnt = 0;
      end
      prev_busy = busy;
      prev_drv  = drv;
    end
  end

  task automatic run_seq(input int hp, input int n, input bit inv_i,
                         input int e_hp, input int e_err, input int e_drv,
                         input int e_busy, input int e_tog, input int e_lat,
                         input bit mid_start);
    exp_t x;
    int   d0;
    x.hp = e_hp; x.err = e_err; x.drv = e_drv;
    x.busy = e_busy; x.tog = e_tog; x.lat = e_lat;
    q.push_back(x);
    @(posedge clk); #1;
    half_period = HP_W'(hp);
    n_toggles   = N_W'(n);
    inv         = inv_i;
    start       = 1'b1;
    d0          = done_seen;
    @(posedge clk); #1;
    start = 1'b0;
    if (mid_start) begin
      repeat (5) @(posedge clk);
      #1;
      half_period = HP_W'(2);
      n_toggles   = N_W'(1);
      start       = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < e_lat + 20 && done_seen == d0; c++) @(posedge clk);
    if (done_seen == d0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("err_cnt_hold_idle", int'(err_cnt), e_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expected dones outstanding", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; half_period = '0; n_toggles = '0; inv = 1'b0;
    #12;
    chk("reset_drv", int'(drv), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    //       hp   n   inv ehp  err  drv busy  tog  lat  mid
    run_seq( 10, 100, 0,  10,    0, 1, 1002, 100, 1003, 0);
    run_seq( 10, 100, 1,  10, 1000, 1, 1002, 100, 1003, 0);
    run_seq(  0,   3, 0,   1,    0, 0,    5,   3,    6, 0);
    run_seq(  0,   3, 1,   1,    3, 0,    5,   3,    6, 0);
    run_seq(  5,   0, 1,   5,    0, 1,    0,   0,    1, 0);
    run_seq(  4,   6, 0,   4,    0, 1,   26,   6,   27, 1);
    run_seq(  2, 255, 1,   2,  510, 0,  512, 255,  513, 0);

    // Abort mid-RUN while drv is low and errors have accumulated.
    @(posedge clk); #1;
    half_period = HP_W'(10); n_toggles = N_W'(100); inv = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_drv", int'(drv), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err_cnt", int'(err_cnt), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run_seq(  3,   5, 0,   3,    0, 0,   17,   5,   18, 0);

    chk("outstanding_expected", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_ctrl.md
TOGGLE_CTRL -- requirements
Module: toggle_ctrl

Interface
REQ-001 Parameter: HP_W, 16, width of half-period field.
REQ-002 Parameter: N_W, 8, width of toggle-count field.
REQ-003 Parameter: LAT, 2, expected DUT response latency in clk cycles (0..15).
REQ-004 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  sequence request, sampled only in IDLE.
REQ-008 half_period  in  HP_W  cycles per drive level; 0 treated as 1.
REQ-009 n_toggles  in  N_W  number of drive-level toggles per sequence.
REQ-010 drv  out  1  stimulus to the DUT input.
REQ-011 rsp  in  1  response from the DUT output.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  one-cycle pulse at sequence end.
REQ-014 err_cnt  out  16  mismatch count of the last sequence, saturating.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-016 IDLE with start=1: latch hp = max(half_period,1) and n = n_toggles, set drv=1, clear err_cnt, clear phase and toggle counters; next state RUN if n!=0, else DONE.
REQ-017 start SHALL be ignored in RUN, DRAIN and DONE; latched hp/n SHALL not change mid-sequence.
REQ-018 RUN: phase counter counts 0..hp-1; at phase hp-1 drv inverts, phase wraps to 0, toggle counter increments.
REQ-019 RUN SHALL last exactly hp*n cycles; the cycle of the n-th toggle moves state to DRAIN.
REQ-020 DRAIN SHALL last exactly LAT cycles (0 cycles when LAT=0, i.e. RUN goes directly to DONE).
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 drv SHALL hold its level in DRAIN, DONE and IDLE; final level equals 1 when n is even, 0 when odd.
REQ-023 Compare pipeline: LAT-deep shift registers of drv and a valid bit (valid=1 for each cycle in RUN); when delayed valid is 1, rsp != delayed drv increments err_cnt.
REQ-024 With LAT=0, compare SHALL use current-cycle drv and RUN state.
REQ-025 Exactly hp*n compares SHALL occur per sequence; no compare in IDLE or DONE.
REQ-026 err_cnt SHALL saturate at 16'hFFFF and hold its value from DONE until the next accepted start.
REQ-027 busy SHALL be 1 from the cycle after accepted start through the last DRAIN cycle; 0 in DONE and IDLE.
REQ-028 Toggle counter width N_W, phase counter width HP_W; no wrap inside a sequence.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, drv=1, busy=0, done=0, err_cnt=0, and clear counters and compare pipeline.
REQ-030 Reset asserted mid-RUN or mid-DRAIN SHALL abort the sequence with no done pulse.
REQ-031 After rst deassert, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-032 hp=10, n=100, rsp = drv through a 2-flop chain -> busy high 1002 cycles, drv 50 high/low pairs of 10 cycles, one done pulse, err_cnt=0, final drv=1.
REQ-033 Same setup, rsp inverted -> err_cnt=1000 at done.
REQ-034 half_period=0, n=3 -> drv toggles every cycle for 3 cycles, final drv=0, done 6 cycles after the start edge (RUN 3 + DRAIN 2 + DONE).
REQ-035 n=0 -> no RUN, done pulses the cycle after start, busy never high, err_cnt=0.
REQ-036 start pulsed during RUN with different hp/n -> ignored, original timing kept; rst pulsed mid-RUN -> drv=1, busy=0 immediately, no done.
